// File: rtl/fir_pkg.sv
// Shared definitions for the serial-arithmetic FIR front end.
//   FIR_BITS       : default sample / FIR data width
//   feeder_state_e : handshake state of the sample feeder
package fir_pkg;

  localparam int unsigned FIR_BITS = 12;

  typedef enum logic {
    FEED_IDLE = 1'b0,
    FEED_BUSY = 1'b1
  } feeder_state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO, DEPTH a power of two.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request and data; ignored when full unless pop is accepted the same cycle
//   pop, dout  : read request (ignored when empty) and head-of-queue data (combinational)
//   full, empty: occupancy flags
//   level      : occupancy 0..DEPTH
module sample_fifo #(
  parameter int unsigned BITS  = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [BITS-1:0]        din,
  output logic [BITS-1:0]        dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [BITS-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // Storage needs no reset: it is only read through a non-empty head.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/fir_sample_feeder.sv
// Upstream feeder for the serial-arithmetic FIR: deserialises an MSB-first
// bit stream into BITS-bit words, queues them, and hands them to the FIR one
// at a time with a start/done handshake.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   enable                : gates new fir_start only; capture and queueing continue
//   s_frame/s_valid/s_data: serial input; a bit is taken when s_frame & s_valid
//   fir_start, fir_x      : 1-cycle start pulse and the held sample
//   fir_done              : 1-cycle completion pulse from the FIR
//   fifo_level            : queue occupancy
//   overflow/frame_err/timeout_err : sticky status, cleared by clr_err
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int unsigned BITS         = FIR_BITS,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned TWOS_IN      = 0,
  parameter int unsigned DONE_TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        s_frame,
  input  logic                        s_valid,
  input  logic                        s_data,
  output logic                        fir_start,
  output logic [BITS-1:0]             fir_x,
  input  logic                        fir_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  output logic                        frame_err,
  output logic                        timeout_err,
  input  logic                        clr_err
);

  localparam int unsigned CNT_W = $clog2(BITS);
  localparam int unsigned TO_W  = $clog2(DONE_TIMEOUT + 1);

  // ---------------- deserialiser ----------------
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [BITS-1:0]  shift_q, shift_d;
  logic [BITS-1:0]  word_raw_c;
  logic [BITS-1:0]  word_c;
  logic             push_c;
  logic             frame_set_c;

  // Completed word = shifted history plus the bit arriving this cycle.
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_c      = 1'b0;
    frame_set_c = 1'b0;
    word_raw_c  = {shift_q[BITS-2:0], s_data};
    word_c      = word_raw_c;
    if (TWOS_IN != 0) word_c[BITS-1] = ~word_raw_c[BITS-1];
    if (!s_frame) begin
      frame_set_c = (bit_cnt_q != '0);
      bit_cnt_d   = '0;
      shift_d     = '0;
    end else if (s_valid) begin
      shift_d = word_raw_c;
      if (bit_cnt_q == CNT_W'(BITS - 1)) begin
        push_c    = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // ---------------- sample queue ----------------
  logic [BITS-1:0] fifo_dout;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop_c;

  sample_fifo #(
    .BITS  (BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_c),
    .pop   (pop_c),
    .din   (word_c),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // ---------------- handshake FSM ----------------
  feeder_state_e   state_q;
  logic [TO_W-1:0] to_cnt_q;
  logic            start_q;
  logic [BITS-1:0] x_q;
  logic            to_set_c;

  assign pop_c    = (state_q == FEED_IDLE) & enable & ~fifo_empty;
  // to_cnt_q holds (BUSY cycles elapsed - 1); done in the expiry cycle wins.
  assign to_set_c = (state_q == FEED_BUSY) & ~fir_done &
                    (to_cnt_q == TO_W'(DONE_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FEED_IDLE;
      to_cnt_q <= '0;
      start_q  <= 1'b0;
      x_q      <= '0;
    end else begin
      start_q <= 1'b0;
      if (state_q == FEED_IDLE) begin
        if (pop_c) begin
          x_q      <= fifo_dout;
          start_q  <= 1'b1;
          to_cnt_q <= '0;
          state_q  <= FEED_BUSY;
        end
      end else begin
        if (fir_done || to_set_c) begin
          state_q <= FEED_IDLE;
        end else begin
          to_cnt_q <= to_cnt_q + TO_W'(1);
        end
      end
    end
  end

  assign fir_start = start_q;
  assign fir_x     = x_q;

  // ---------------- sticky status ----------------
  logic overflow_q, overflow_d;
  logic frame_err_q, frame_err_d;
  logic timeout_q, timeout_d;

  // clr_err wins over a set in the same cycle.
  always_comb begin
    overflow_d  = overflow_q  | (push_c & fifo_full & ~pop_c);
    frame_err_d = frame_err_q | frame_set_c;
    timeout_d   = timeout_q   | to_set_c;
    if (clr_err) begin
      overflow_d  = 1'b0;
      frame_err_d = 1'b0;
      timeout_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      frame_err_q <= frame_err_d;
      timeout_q   <= timeout_d;
    end
  end

  assign overflow    = overflow_q;
  assign frame_err   = frame_err_q;
  assign timeout_err = timeout_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Self-checking bench for fir_sample_feeder: a queue-based model is compared
// every cycle against two instances (TWOS_IN = 0 and 1) driven identically.
module tb_fir_sample_feeder;

  localparam int unsigned BITS  = 12;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 255;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, s_frame, s_valid, s_data, clr_err;
  logic fir_done = 1'b0;

  logic            start0, start1;
  logic [BITS-1:0] x0, x1;
  logic [2:0]      lvl0, lvl1;
  logic            ovf0, ovf1, fe0, fe1, to0, to1;

  fir_sample_feeder #(.BITS(BITS), .FIFO_DEPTH(DEPTH), .TWOS_IN(0), .DONE_TIMEOUT(TMO)) dut0 (
    .clk(clk), .rst(rst), .enable(enable), .s_frame(s_frame), .s_valid(s_valid),
    .s_data(s_data), .fir_start(start0), .fir_x(x0), .fir_done(fir_done),
    .fifo_level(lvl0), .overflow(ovf0), .frame_err(fe0), .timeout_err(to0),
    .clr_err(clr_err));

  fir_sample_feeder #(.BITS(BITS), .FIFO_DEPTH(DEPTH), .TWOS_IN(1), .DONE_TIMEOUT(TMO)) dut1 (
    .clk(clk), .rst(rst), .enable(enable), .s_frame(s_frame), .s_valid(s_valid),
    .s_data(s_data), .fir_start(start1), .fir_x(x1), .fir_done(fir_done),
    .fifo_level(lvl1), .overflow(ovf1), .frame_err(fe1), .timeout_err(to1),
    .clr_err(clr_err));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Outputs of cycle t+1 are computed from the inputs of cycle t.
  int            m_nbits;
  int            m_acc;
  logic [11:0]   m_q[$];
  bit            m_busy;
  int            m_busy_cyc;
  logic          m_start;
  logic [11:0]   m_x, m_x1;
  logic          m_ovf, m_fe, m_to;
  bit            m_pop, m_push;
  logic [11:0]   m_w;

  always @(posedge clk) begin
    if (rst) begin
      m_nbits = 0; m_acc = 0; m_q.delete();
      m_busy = 0; m_busy_cyc = 0; m_start = 0; m_x = 0; m_x1 = 0;
      m_ovf = 0; m_fe = 0; m_to = 0;
    end else begin
      m_pop  = !m_busy && enable && (m_q.size() > 0);
      m_push = 0;
      m_start = 0;
      if (m_pop) begin
        m_x = m_q.pop_front();
        m_x1 = m_x ^ 12'h800;
        m_start = 1; m_busy = 1; m_busy_cyc = 1;
      end else if (m_busy) begin
        if (fir_done) m_busy = 0;
        else if (m_busy_cyc == TMO) begin m_to = 1; m_busy = 0; end
        else m_busy_cyc++;
      end
      if (!s_frame) begin
        if (m_nbits != 0) m_fe = 1;
        m_nbits = 0; m_acc = 0;
      end else if (s_valid) begin
        m_acc = m_acc * 2 + int'(s_data);
        m_nbits++;
        if (m_nbits == BITS) begin
          m_w = m_acc[11:0];
          m_push = 1; m_nbits = 0; m_acc = 0;
        end
      end
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(m_w);
        else m_ovf = 1;
      end
      if (clr_err) begin m_ovf = 0; m_fe = 0; m_to = 0; end
    end
  end

  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("fir_start0", start0, m_start);
      chk("fir_start1", start1, m_start);
      chk("fir_x0", x0, m_x);
      chk("fir_x1", x1, m_x1);
      chk("fifo_level0", lvl0, m_q.size());
      chk("fifo_level1", lvl1, m_q.size());
      chk("overflow", ovf0, m_ovf);
      chk("frame_err", fe0, m_fe);
      chk("timeout_err", to0, m_to);
      chk("flags1", {ovf1, fe1, to1}, {m_ovf, m_fe, m_to});
    end
  end

  // ---------------- FIR responder ----------------
  int cd = 0;
  bit respond = 1;
  bit spur = 0;
  int lat = 48;
  always @(posedge clk) begin
    #2;
    fir_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) fir_done = 1'b1;
    end
    if (spur && $urandom_range(0, 40) == 0) fir_done = 1'b1;
    if (start0 === 1'b1 && respond) cd = lat;
  end

  // ---------------- start log ----------------
  int          cyc = 0;
  int          n_starts = 0;
  int          last_done = -1;
  logic [11:0] sx0[$], sx1[$];
  int          gaps[$];
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (start0 === 1'b1) begin
      n_starts++;
      sx0.push_back(x0);
      sx1.push_back(x1);
      if (last_done >= 0) gaps.push_back(cyc - last_done);
      last_done = -1;
    end
    if (fir_done) last_done = cyc;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_word(input logic [11:0] w);
    for (int i = BITS - 1; i >= 0; i--) begin
      s_frame = 1'b1; s_valid = 1'b1; s_data = w[i];
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic frame_end();
    s_frame = 1'b0; s_valid = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1; tick(); clr_err = 1'b0;
  endtask

  int base;
  logic [11:0] exp_w;

  initial begin
    rst = 1'b1; enable = 1'b0; s_frame = 1'b0; s_valid = 1'b0; s_data = 1'b0; clr_err = 1'b0;
    ticks(2);
    chk_en = 1;
    chk("rst_outputs", {start0, x0, lvl0, ovf0, fe0, to0}, 32'h0);
    rst = 1'b0;
    enable = 1'b1;

    // single word, done 48 cycles after start
    lat = 48;
    send_word(12'hA5C);
    frame_end();
    ticks(60);
    chk("t1_starts", n_starts, 1);
    chk("t1_x", sx0[0], 12'hA5C);
    chk("t1_x_twos", sx1[0], 12'h25C);
    chk("t1_level", lvl0, 0);

    // two's complement mapping at the extremes
    lat = 4;
    send_word(12'h800);
    send_word(12'h7FF);
    frame_end();
    ticks(30);
    chk("t2_twos_min", sx1[1], 12'h000);
    chk("t2_twos_max", sx1[2], 12'hFFF);
    chk("t2_plain", sx0[1], 12'h800);

    // three back-to-back words queued, then released
    enable = 1'b0;
    lat = 6;
    send_word(12'h111); send_word(12'h222); send_word(12'h333);
    frame_end();
    ticks(3);
    chk("t3_level", lvl0, 3);
    base = n_starts;
    gaps.delete();
    last_done = -1;
    enable = 1'b1;
    ticks(40);
    chk("t3_starts", n_starts - base, 3);
    for (int i = 0; i < 3; i++) begin
      exp_w = 12'h111 * 12'(i + 1);
      chk("t3_order", sx0[base + i], exp_w);
    end
    chk("t3_ngaps", gaps.size(), 2);
    foreach (gaps[i]) chk("t3_gap", gaps[i], 2);

    // overflow: six words into four slots
    enable = 1'b0;
    for (int i = 1; i <= 6; i++) send_word(12'(12'h100 + i));
    frame_end();
    ticks(2);
    chk("t4_level", lvl0, 4);
    chk("t4_overflow", ovf0, 1);
    pulse_clr();
    chk("t4_cleared", ovf0, 0);
    base = n_starts;
    lat = 3;
    enable = 1'b1;
    ticks(40);
    chk("t4_starts", n_starts - base, 4);
    for (int i = 0; i < 4; i++) chk("t4_order", sx0[base + i], 12'(12'h101 + i));

    // framing error after 7 bits, then a clean frame
    for (int i = 0; i < 7; i++) begin
      s_frame = 1'b1; s_valid = 1'b1; s_data = 1'($urandom_range(0, 1));
      tick();
    end
    frame_end();
    tick();
    chk("t5_frame_err", fe0, 1);
    chk("t5_no_push", lvl0, 0);
    pulse_clr();
    base = n_starts;
    send_word(12'h123);
    frame_end();
    ticks(20);
    chk("t5_starts", n_starts - base, 1);
    chk("t5_x", sx0[$], 12'h123);

    // done withheld -> timeout, next word started
    respond = 0;
    enable = 1'b0;
    send_word(12'h0AA); send_word(12'h0BB);
    frame_end();
    base = n_starts;
    enable = 1'b1;
    ticks(10);
    chk("t6_no_timeout_yet", to0, 0);
    ticks(255);
    chk("t6_timeout", to0, 1);
    chk("t6_next_started", n_starts - base, 2);
    chk("t6_next_x", sx0[$], 12'h0BB);
    ticks(260);
    pulse_clr();
    respond = 1;

    // reset while busy with two words queued
    enable = 1'b0;
    respond = 0;
    send_word(12'h321); send_word(12'h654); send_word(12'h987);
    frame_end();
    enable = 1'b1;
    ticks(5);
    chk("t7_queued", lvl0, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t7_rst_outputs", {start0, x0, lvl0, ovf0, fe0, to0}, 32'h0);
    base = n_starts;
    respond = 1;
    ticks(20);
    chk("t7_no_start", n_starts - base, 0);

    // randomized traffic
    spur = 1;
    for (int c = 0; c < 5000; c++) begin
      s_frame = ($urandom_range(0, 99) != 0);
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 7) != 0);
      clr_err = ($urandom_range(0, 199) == 0);
      rst     = ($urandom_range(0, 1499) == 0);
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 30);
      if ($urandom_range(0, 99) == 0) respond = ($urandom_range(0, 5) != 0);
      tick();
    end
    rst = 1'b0; clr_err = 1'b0; s_frame = 1'b0; s_valid = 1'b0;
    tick();
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
